// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, one-outstanding memory read, output register plus one-entry skid.
// Optional misaligned-branch fault state enabled by the FETCH_ALIGN_CHECK_EN macro.
module instruction_fetch #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        branch,
  input  logic [31:0] branchTarget,
  output logic        memReq,
  output logic [31:0] memAddress,
  input  logic        memReady,
  input  logic [31:0] memData,
  output logic [31:0] instrOut,
  output logic [31:0] pcOut,
  output logic        instrValid,
  input  logic        instrReady,
  output logic        fault,
  output logic [1:0]  dbg_state_o
);

`ifdef FETCH_ALIGN_CHECK_EN
  typedef enum logic [1:0] {S_FETCH = 2'd0, S_HOLD = 2'd1, S_FAULT = 2'd2} state_e;
`else
  typedef enum logic [1:0] {S_FETCH = 2'd0, S_HOLD = 2'd1} state_e;
`endif

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;

  logic        in_fault;
  logic        misaligned;
  logic [31:0] target_aligned;

  assign target_aligned = branchTarget & ~32'h3;
`ifdef FETCH_ALIGN_CHECK_EN
  assign in_fault   = (state_q == S_FAULT);
  assign misaligned = (branchTarget[1:0] != 2'b00);
`else
  assign in_fault   = 1'b0;
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_ADDR;
      instr_q      <= 32'h0;
      pc_out_q     <= 32'h0;
      valid_q      <= 1'b0;
      skid_instr_q <= 32'h0;
      skid_pc_q    <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      pc_out_q     <= pc_out_d;
      valid_q      <= valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  // Handshake: a word moves to decode on any edge where instrValid && instrReady;
  // HOLD means the skid register is full and the output register is still waiting.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    pc_out_d     = pc_out_q;
    valid_d      = valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    if (branch && !in_fault) begin
      valid_d      = 1'b0;
      skid_instr_d = 32'h0;
      skid_pc_d    = 32'h0;
      if (misaligned) begin
`ifdef FETCH_ALIGN_CHECK_EN
        state_d = S_FAULT;
`endif
      end else begin
        state_d = S_FETCH;
        pc_d    = target_aligned;
      end
    end else begin
      unique case (state_q)
        S_FETCH: begin
          if (memReady) begin
            pc_d = pc_q + 32'd4;
            if (!valid_q || instrReady) begin
              instr_d  = memData;
              pc_out_d = pc_q;
              valid_d  = 1'b1;
            end else begin
              skid_instr_d = memData;
              skid_pc_d    = pc_q;
              state_d      = S_HOLD;
            end
          end else if (valid_q && instrReady) begin
            valid_d = 1'b0;
          end
        end
        S_HOLD: begin
          if (instrReady) begin
            instr_d  = skid_instr_q;
            pc_out_d = skid_pc_q;
            valid_d  = 1'b1;
            state_d  = S_FETCH;
          end
        end
        default: begin
          // Fault is sticky until reset; anything else is an illegal encoding.
          if (!in_fault) state_d = S_FETCH;
        end
      endcase
    end
  end

  always_comb begin
    memReq      = (state_q == S_FETCH);
    fault       = in_fault;
    dbg_state_o = state_q;
  end

  assign memAddress = pc_q;
  assign instrOut   = instr_q;
  assign pcOut      = pc_out_q;
  assign instrValid = valid_q;

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter: RESET_ADDR, 32'h00000000, PC value loaded on reset.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: branch  input  1  redirect request, one-cycle pulse.
REQ-005 SHALL have port: branchTarget  input  32  redirect address, sampled when branch=1.
REQ-006 SHALL have port: memReq  output  1  instruction-memory read request.
REQ-007 SHALL have port: memAddress  output  32  read address, equal to the PC register.
REQ-008 SHALL have port: memReady  input  1  memory returns memData this cycle.
REQ-009 SHALL have port: memData  input  32  instruction word.
REQ-010 SHALL have port: instrOut  output  32  fetched instruction to decode.
REQ-011 SHALL have port: pcOut  output  32  address of instrOut.
REQ-012 SHALL have port: instrValid  output  1  instrOut/pcOut valid.
REQ-013 SHALL have port: instrReady  input  1  decode accepts instrOut when instrValid=1.
REQ-014 SHALL have port: fault  output  1  misaligned-branch fault (see REQ-032).

Function
REQ-015 SHALL implement states FETCH, HOLD and FAULT; FAULT exists only per REQ-032.
REQ-016 SHALL drive memReq=1 in FETCH and memReq=0 in HOLD and FAULT, decoded from registered state.
REQ-017 SHALL hold memAddress stable while memReq=1, until the memReady cycle or a branch cycle.
REQ-018 SHALL define capture as FETCH && memReady && !branch && (!instrValid || instrReady).
REQ-019 On capture, at the next edge: instrOut<=memData, pcOut<=PC, instrValid<=1, PC<=PC+4; state stays FETCH. Latency from memReady to instrValid is one cycle.
REQ-020 In FETCH with memReady=1, instrValid=1 and instrReady=0: SHALL latch memData into a one-entry skid register and go to HOLD, with PC<=PC+4.
REQ-021 In HOLD with instrReady=1: SHALL move the skid entry to instrOut/pcOut, keep instrValid=1 and return to FETCH. The transfer SHALL complete without losing a word.
REQ-022 With instrValid=1, instrReady=1 and no new capture: SHALL clear instrValid at the next edge.
REQ-023 PC arithmetic SHALL be modulo 2^32: 32'hFFFFFFFC+4 yields 32'h00000000.
REQ-024 branch SHALL have highest priority below reset. At the next edge: PC<=branchTarget, instrValid<=0, skid cleared, state<=FETCH. A memReady in the same cycle SHALL be discarded.
REQ-025 A branch in HOLD SHALL discard both the output entry and the skid entry.
REQ-026 instrOut and pcOut SHALL hold their values while instrValid=1 and instrReady=0.

Reset
REQ-027 When reset=1 at a rising edge: PC<=RESET_ADDR, state<=FETCH, instrValid<=0, instrOut<=0, pcOut<=0, skid cleared, fault<=0.
REQ-028 Reset SHALL override branch, memReady and instrReady in the same cycle.
REQ-029 Reset asserted mid-request SHALL abandon the request, and the first memReq after reset SHALL use RESET_ADDR.
REQ-030 memReq SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-031 SHALL use macro FETCH_ALIGN_CHECK_EN.
REQ-032 With FETCH_ALIGN_CHECK_EN defined: a branch with branchTarget[1:0]!=0 SHALL enter FAULT. FAULT sets fault=1, memReq=0 and instrValid=0 until reset. PC SHALL be left unchanged.
REQ-033 Without FETCH_ALIGN_CHECK_EN: the design SHALL force branchTarget[1:0] to 2'b00, tie fault to 0 and omit the FAULT state.

Verification
REQ-034 Reset with RESET_ADDR=0, memReady=1 every cycle, instrReady=1 -> memAddress 0,4,8 on consecutive cycles; instrValid=1 from cycle 2 with pcOut 0,4,8.
REQ-035 instrReady=0 for 3 cycles with memReady=1 -> memReq drops after one extra word. Once instrReady=1, both words come out in order with no loss or duplication.
REQ-036 branch=1, branchTarget=32'h100 in the same cycle as memReady=1 -> that word is dropped, the next memAddress is 32'h100 and instrValid=0 for one cycle.
REQ-037 PC=32'hFFFFFFFC with a capture -> next memAddress is 32'h00000000.
REQ-038 With the macro defined, branchTarget=32'h102 -> fault=1 and memReq=0 are held; reset then gives fault=0 and memAddress=RESET_ADDR. Without the macro, the same stimulus gives memAddress 32'h100.
REQ-039 reset=1 asserted while memReq=1 and memReady=0 -> next cycle has memAddress=RESET_ADDR and instrValid=0.
